mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/data_ram.sv | 31 +++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_pkg : shared RISC-V pipeline encodings (ALU ops, mem sizes)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // The unused fourth encoding behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? MEM_W : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_ram : byte-enabled synchronous single-port RAM, read-first    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module data_ram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clock,
    input  logic                           rd_en,
    input  logic [3:0]                     byte_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wr_data,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage : pipeline MEM stage, load/store lane steering + MEM/WB  |
// | Optional: MEM_MISALIGN_CHECK_EN traps misaligned half/word access. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_stage
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc4,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic        branch_result,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    output logic [31:0] pc4_pass,
    output logic [31:0] alu_pass,
    output logic [31:0] load_data,
    output logic [4:0]  rd_pass,
    output logic        reg_write_pass,
    output logic        mem_to_reg_pass,
    output logic        branch_taken,
    output logic        misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]       size;
    logic [1:0]       offset;
    logic             bad;
    logic             go;
    logic             do_store;
    logic             do_load;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data;
    logic [IDX_W-1:0] index;
    logic [31:0]      rd_data;
    logic             load_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign size  = norm_size(mem_size);
    assign index = address[IDX_W+1:2];

    // Offending low bits are dropped so every access lands aligned.
    always_comb begin
        offset = address[1:0];
        case (size)
            MEM_H:   offset[0] = 1'b0;
            MEM_W:   offset    = 2'b00;
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic bad_raw;
    logic mis_q;

    always_comb begin
        case (size)
            MEM_H:   bad_raw = address[0];
            MEM_W:   bad_raw = |address[1:0];
            default: bad_raw = 1'b0;
        endcase
    end

    assign bad        = bad_raw & (mem_read | mem_write);
    assign misaligned = mis_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (!stall) begin
            mis_q <= bad;
        end
    end
`else
    assign bad        = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign go       = !stall && !reset;
    assign do_store = go && mem_write && !bad;
    assign do_load  = go && mem_read && !mem_write && !bad;

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = wr_data;
        case (size)
            MEM_B: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{wr_data[7:0]}};
            end
            MEM_H: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wr_data[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
        if (!do_store) begin
            byte_en = 4'b0000;
        end
    end

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_data_ram (
        .clock   (clock),
        .rd_en   (do_load),
        .byte_en (byte_en),
        .addr    (index),
        .wr_data (lane_data),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pc4_pass        <= '0;
            alu_pass        <= '0;
            rd_pass         <= '0;
            reg_write_pass  <= 1'b0;
            mem_to_reg_pass <= 1'b0;
            branch_taken    <= 1'b0;
            load_q          <= 1'b0;
            off_q           <= 2'b00;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
        end else if (!stall) begin
            pc4_pass        <= pc4;
            alu_pass        <= address;
            rd_pass         <= rd;
            reg_write_pass  <= reg_write && !bad;
            mem_to_reg_pass <= mem_to_reg;
            branch_taken    <= branch_result;
            load_q          <= do_load;
            off_q           <= offset;
            size_q          <= size;
            uns_q           <= mem_unsigned;
        end
    end

    // RAM output is held while stalled, so the extracted value holds too.
    assign byte_sel = rd_data[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? rd_data[31:16] : rd_data[15:0];

    always_comb begin
        load_data = '0;
        if (load_q) begin
            case (size_q)
                MEM_B:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
                MEM_H:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
                default: load_data = rd_data;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage : directed bench with byte-array reference model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_stage;

    localparam int DEPTH = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clock = 1'b0;
    logic        reset, stall;
    logic [31:0] pc4, address, wr_data;
    logic        branch_result, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [4:0]  rd;
    logic        reg_write, mem_to_reg;
    logic [31:0] pc4_pass, alu_pass, load_data;
    logic [4:0]  rd_pass;
    logic        reg_write_pass, mem_to_reg_pass, branch_taken, misaligned;

    mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .pc4(pc4), .address(address), .wr_data(wr_data),
        .branch_result(branch_result), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc4_pass(pc4_pass), .alu_pass(alu_pass), .load_data(load_data),
        .rd_pass(rd_pass), .reg_write_pass(reg_write_pass),
        .mem_to_reg_pass(mem_to_reg_pass), .branch_taken(branch_taken),
        .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [NBYTES];
    logic [31:0] e_pc4, e_alu, e_ld;
    logic [4:0]  e_rd;
    logic        e_rw, e_m2r, e_br, e_mis;
    bit          model_on = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory is a flat little-endian byte array; accesses are byte runs.
    always @(posedge clock) begin : model_p
        int          nb, base;
        logic [31:0] al, v;
        bit          bad;
        if (reset) begin
            e_pc4 = 0; e_alu = 0; e_ld = 0; e_rd = 0;
            e_rw = 0; e_m2r = 0; e_br = 0; e_mis = 0;
            model_on = 1;
        end else if (!stall) begin
            nb  = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
            bad = 0;
`ifdef MEM_MISALIGN_CHECK_EN
            bad = (mem_read || mem_write) && ((address % 32'(nb)) != 0);
`endif
            al   = address - (address % 32'(nb));
            base = int'(al % 32'(NBYTES));
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (32'(mb[base + i]) << (8 * i));
            if (!mem_unsigned && nb == 1 && v[7])  v[31:8]  = '1;
            if (!mem_unsigned && nb == 2 && v[15]) v[31:16] = '1;
            e_ld = (mem_read && !mem_write && !bad) ? v : 32'd0;
            if (mem_write && !bad)
                for (int i = 0; i < nb; i++) mb[base + i] = wr_data[8*i +: 8];
            e_pc4 = pc4; e_alu = address; e_rd = rd;
            e_rw = reg_write && !bad; e_m2r = mem_to_reg; e_br = branch_result;
            e_mis = bad;
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            cmp("pc4_pass", pc4_pass, e_pc4);
            cmp("alu_pass", alu_pass, e_alu);
            cmp("load_data", load_data, e_ld);
            cmp("rd_pass", 32'(rd_pass), 32'(e_rd));
            cmp("reg_write_pass", 32'(reg_write_pass), 32'(e_rw));
            cmp("mem_to_reg_pass", 32'(mem_to_reg_pass), 32'(e_m2r));
            cmp("branch_taken", 32'(branch_taken), 32'(e_br));
            cmp("misaligned", 32'(misaligned), 32'(e_mis));
        end
    end

    task automatic idle();
        stall = 0; reset = 0; mem_read = 0; mem_write = 0; mem_size = 2'd2;
        mem_unsigned = 0; pc4 = 0; address = 0; wr_data = 0; branch_result = 0;
        rd = 0; reg_write = 0; mem_to_reg = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        idle(); mem_write = 1; address = a; mem_size = sz; wr_data = d;
        tick();
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        idle(); mem_read = 1; address = a; mem_size = sz; mem_unsigned = uns;
        reg_write = 1; mem_to_reg = 1; rd = 5'd10;
        tick();
    endtask

    initial begin
        idle();
        reset = 1; pc4 = 32'h1234; address = 32'h55; reg_write = 1; branch_result = 1;
        tick();
        cmp("reset_pc4", pc4_pass, 32'h0);
        cmp("reset_rw", 32'(reg_write_pass), 32'h0);
        cmp("reset_br", 32'(branch_taken), 32'h0);

        st(32'h40, 2'd2, 32'h12345678);
        idle(); reset = 1; mem_write = 1; address = 32'h40; wr_data = 32'hFFFFFFFF;
        tick();
        ld(32'h40, 2'd2, 0);
        cmp("reset_store_suppressed", load_data, 32'h12345678);

        st(32'h10, 2'd2, 32'hDEADBEEF);
        ld(32'h10, 2'd2, 0);
        cmp("lw_deadbeef", load_data, 32'hDEADBEEF);
        cmp("lw_rd_pass", 32'(rd_pass), 32'd10);

        st(32'h20, 2'd2, 32'h000080F0);
        ld(32'h20, 2'd0, 0);
        cmp("lb_signed", load_data, 32'hFFFFFFF0);
        ld(32'h20, 2'd0, 1);
        cmp("lbu", load_data, 32'h000000F0);
        ld(32'h20, 2'd1, 0);
        cmp("lh_signed", load_data, 32'hFFFF80F0);

        st(32'h10, 2'd2, 32'h11223344);
        st(32'h13, 2'd0, 32'h000000AA);
        ld(32'h10, 2'd2, 0);
        cmp("sb_partial", load_data, 32'hAA223344);

        idle(); pc4 = 32'd204; address = 32'd7; branch_result = 1; rd = 5'd5; reg_write = 1;
        tick();
        cmp("pass_pc4", pc4_pass, 32'd204);
        cmp("pass_alu", alu_pass, 32'd7);
        cmp("pass_br", 32'(branch_taken), 32'd1);
        cmp("pass_rd", 32'(rd_pass), 32'd5);
        cmp("pass_noload", load_data, 32'd0);

        idle(); stall = 1; mem_write = 1; address = 32'h10; wr_data = 32'h0; pc4 = 32'd999;
        tick();
        cmp("stall_hold_pc4", pc4_pass, 32'd204);
        ld(32'h10, 2'd2, 0);
        cmp("stall_store_suppressed", load_data, 32'hAA223344);
        idle(); stall = 1; mem_read = 1; address = 32'h20;
        tick();
        cmp("stall_hold_load", load_data, 32'hAA223344);

        idle(); reset = 1; mem_read = 1; address = 32'h10; pc4 = 32'd8;
        tick();
        cmp("reset_midload_ld", load_data, 32'h0);
        cmp("reset_midload_pc4", pc4_pass, 32'h0);

        st(32'h22, 2'd1, 32'h0000BEEF);
        ld(32'h22, 2'd1, 1);
        cmp("lhu_upper", load_data, 32'h0000BEEF);
        ld(32'h20, 2'd2, 0);
        cmp("sh_merge", load_data, 32'hBEEF80F0);

        ld(32'h22, 2'd2, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        cmp("mis_flag", 32'(misaligned), 32'd1);
        cmp("mis_ld", load_data, 32'h0);
        cmp("mis_rw", 32'(reg_write_pass), 32'd0);
`else
        cmp("mis_flag", 32'(misaligned), 32'd0);
        cmp("mis_ld_aligned", load_data, 32'hBEEF80F0);
        cmp("mis_rw", 32'(reg_write_pass), 32'd1);
`endif
        st(32'h22, 2'd2, 32'h0);
        ld(32'h20, 2'd2, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        cmp("mis_store_suppressed", load_data, 32'hBEEF80F0);
`else
        cmp("mis_store_aligned", load_data, 32'h0);
`endif

        ld(32'h00000410, 2'd2, 0);
        cmp("wrap_depth", load_data, 32'hAA223344);
        ld(32'h80000010, 2'd2, 0);
        cmp("wrap_high", load_data, 32'hAA223344);

        st(32'h30, 2'd3, 32'hCAFEF00D);
        ld(32'h30, 2'd3, 0);
        cmp("size3_word", load_data, 32'hCAFEF00D);
        ld(32'h31, 2'd0, 0);
        cmp("lb_lane1", load_data, 32'hFFFFFFF0);

        idle(); mem_read = 1; mem_write = 1; address = 32'h30; wr_data = 32'h01020304;
        tick();
        cmp("rw_both_ld0", load_data, 32'h0);
        ld(32'h30, 2'd2, 0);
        cmp("rw_both_stored", load_data, 32'h01020304);
        ld(32'h33, 2'd1, 0);
`ifndef MEM_MISALIGN_CHECK_EN
        cmp("lh_aligned_down", load_data, 32'h00000102);
`endif

        idle();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
